// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
package alu_sched_pkg;

  localparam int unsigned NUM_REQ = 2;

  localparam logic [4:0] ALU_CTRL_MUL = 5'b01010;

  // Bit positions inside rsp_flags = {zero, neg, lt}
  localparam int unsigned FLAG_ZERO = 2;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_LT   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: last_i is the index granted most recently.
module rr_arbiter2
  import alu_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external ALU between two requesters: grant, execute, respond.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_op1,
  input  logic [32*NUM_REQ-1:0]   req_op2,
  input  logic [5*NUM_REQ-1:0]    req_ctrl,
  output logic [31:0]             alu_op1,
  output logic [31:0]             alu_op2,
  output logic [4:0]              alu_ctrl,
  input  logic [31:0]             alu_result,
  input  logic                    alu_zero,
  input  logic                    alu_neg,
  input  logic                    alu_lt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [31:0]             rsp_result,
  output logic [2:0]              rsp_flags
);

  localparam logic [3:0] CNT_MUL = 4'(MUL_CYCLES - 1);

  state_t      state_q;
  logic        last_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [4:0]  ctrl_q;
  logic        id_q;
  logic [3:0]  cnt_q;
  logic [31:0] res_q;
  logic [2:0]  flags_q;

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_idx;
  logic [31:0]        op1_sel;
  logic [31:0]        op2_sel;
  logic [4:0]         ctrl_sel;

  rr_arbiter2 u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign gnt_idx  = gnt[1];
  assign op1_sel  = gnt_idx ? req_op1[63:32] : req_op1[31:0];
  assign op2_sel  = gnt_idx ? req_op2[63:32] : req_op2[31:0];
  assign ctrl_sel = gnt_idx ? req_ctrl[9:5]  : req_ctrl[4:0];

  // Grant is combinational from IDLE; rst_n gating keeps it quiet during reset.
  assign req_ready = (state_q == IDLE && rst_n) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      op1_q   <= '0;
      op2_q   <= '0;
      ctrl_q  <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt != '0) begin
            op1_q   <= op1_sel;
            op2_q   <= op2_sel;
            ctrl_q  <= ctrl_sel;
            id_q    <= gnt_idx;
            last_q  <= gnt_idx;
            cnt_q   <= (ctrl_sel == ALU_CTRL_MUL) ? CNT_MUL : '0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            res_q              <= alu_result;
            flags_q[FLAG_ZERO] <= alu_zero;
            flags_q[FLAG_NEG]  <= alu_neg;
            flags_q[FLAG_LT]   <= alu_lt;
            state_q            <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;

endmodule
